// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial line, frame options and word delivery handshake
// shared by the frame receiver and whatever drives or consumes it.
interface serial_frame_receiver_if #(
   parameter int WIDTH = 4
);
   logic             ser_in;
   logic             ser_valid;
   logic             dir;
   logic             parity_en;
   logic             parity_odd;
   logic             data_ack;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             parity_err;
   logic             frame_err;
   logic             overrun;
   logic             busy;

   modport master (
      output ser_in, ser_valid, dir, parity_en, parity_odd, data_ack,
      input  data_out, data_valid, parity_err, frame_err, overrun, busy
   );

   modport slave (
      input  ser_in, ser_valid, dir, parity_en, parity_odd, data_ack,
      output data_out, data_valid, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start, WIDTH data bits, optional parity, stop.
// Rebuilds the word and hands it out through a valid/ack holding register.
module serial_frame_receiver #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_frame_receiver_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             perr_q, perr_d;
   logic             dir_q, dir_d;
   logic             pen_q, pen_d;
   logic             podd_q, podd_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dvalid_q, dvalid_d;
   logic             perr_out_q, perr_out_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             good_stop, bad_stop;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.ser_valid) begin
         case (state_q)
            IDLE:    if (!bus.ser_in) state_d = DATA;
            DATA:    if (cnt_q == LAST_BIT) state_d = pen_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every *_d starts from its flop value, so no path infers a latch.
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      par_d  = par_q;
      perr_d = perr_q;
      dir_d  = dir_q;
      pen_d  = pen_q;
      podd_d = podd_q;
      if (bus.ser_valid) begin
         case (state_q)
            IDLE: begin
               // Frame options are frozen at the start bit for the whole frame.
               if (!bus.ser_in) begin
                  dir_d  = bus.dir;
                  pen_d  = bus.parity_en;
                  podd_d = bus.parity_odd;
                  cnt_d  = '0;
                  par_d  = 1'b0;
                  perr_d = 1'b0;
               end
            end
            DATA: begin
               sreg_d = dir_q ? {sreg_q[WIDTH-2:0], bus.ser_in}
                              : {bus.ser_in, sreg_q[WIDTH-1:1]};
               par_d  = par_q ^ bus.ser_in;
               cnt_d  = cnt_q + CW'(1);
            end
            PARITY:  perr_d = par_q ^ bus.ser_in ^ podd_q;
            default: ;
         endcase
      end
   end

   assign good_stop = bus.ser_valid && (state_q == STOP) && bus.ser_in;
   assign bad_stop  = bus.ser_valid && (state_q == STOP) && !bus.ser_in;

   always_comb begin
      data_d     = data_q;
      dvalid_d   = dvalid_q;
      perr_out_d = perr_out_q;
      ovr_d      = ovr_q;
      ferr_d     = bad_stop;
      if (good_stop) begin
         // A same-cycle ack frees the holding register for the new word.
         if (!dvalid_q || bus.data_ack) begin
            data_d     = sreg_q;
            perr_out_d = perr_q;
            dvalid_d   = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (bus.data_ack && dvalid_q) begin
         dvalid_d   = 1'b0;
         perr_out_d = 1'b0;
         ovr_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q     <= '0;
         cnt_q      <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         dir_q      <= 1'b0;
         pen_q      <= 1'b0;
         podd_q     <= 1'b0;
         data_q     <= '0;
         dvalid_q   <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         dir_q      <= dir_d;
         pen_q      <= pen_d;
         podd_q     <= podd_d;
         data_q     <= data_d;
         dvalid_q   <= dvalid_d;
         perr_out_q <= perr_out_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   always_comb begin
      bus.busy       = (state_q != IDLE);
      bus.data_out   = data_q;
      bus.data_valid = dvalid_q;
      bus.parity_err = perr_out_q;
      bus.frame_err  = ferr_q;
      bus.overrun    = ovr_q;
   end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver (WIDTH=4): scenario tasks
// plus a scoreboard of expected {parity_err, word} deliveries.
module tb_serial_frame_receiver;
   localparam int WIDTH = 4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   serial_frame_receiver_if #(.WIDTH(WIDTH)) bus ();

   serial_frame_receiver #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [WIDTH:0]   sb_q[$];
   logic [WIDTH-1:0] m_word  = '0;
   bit               m_valid = 0;
   bit               m_ovr   = 0;

   // Output monitor: a new word is presented when data_valid rises or stays
   // high across an accepted ack (completion in the same cycle as the ack).
   bit vld_prev = 0;
   bit ack_prev = 0;
   always @(negedge clk) begin
      if (!rst && bus.data_valid && (!vld_prev || ack_prev)) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected: got word=%b perr=%b, expected no delivery",
                     bus.data_out, bus.parity_err);
         end else begin
            logic [WIDTH:0] exp;
            exp = sb_q.pop_front();
            if ({bus.parity_err, bus.data_out} !== exp) begin
               errors++;
               $display("FAIL deliver_word: got perr=%b word=%b, expected perr=%b word=%b",
                        bus.parity_err, bus.data_out, exp[WIDTH], exp[WIDTH-1:0]);
            end
         end
      end
      vld_prev = bus.data_valid;
      ack_prev = bus.data_ack;
   end

   // seq[WIDTH-1] goes on the line first.
   task automatic send_frame(input logic d, input logic pen, input logic podd,
                             input logic [WIDTH-1:0] seq, input logic pbit,
                             input logic stop, input logic ack_at_stop, input bit gaps);
      logic             bits[$];
      logic [WIDTH-1:0] exp_word;
      logic             exp_perr;
      int               n;
      bits.push_back(1'b0);
      for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(seq[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(stop);
      n = bits.size();
      for (int i = 0; i < WIDTH; i++) exp_word[i] = d ? seq[i] : seq[WIDTH-1-i];
      exp_perr = pen ? (^seq ^ pbit ^ podd) : 1'b0;

      for (int k = 0; k < n; k++) begin
         bus.ser_in    = bits[k];
         bus.ser_valid = 1'b1;
         if (k == 0) begin
            bus.dir        = d;
            bus.parity_en  = pen;
            bus.parity_odd = podd;
         end
         if (k == n - 1) bus.data_ack = ack_at_stop;
         @(posedge clk);
         #1;
         bus.data_ack = 1'b0;
         if (k == 0) begin
            // Flip options mid-frame; the receiver must ignore this.
            bus.dir        = ~d;
            bus.parity_en  = ~pen;
            bus.parity_odd = ~podd;
            checks++;
            if (bus.frame_err !== 1'b0) begin
               errors++;
               $display("FAIL frame_err_idle: got %b, expected 0", bus.frame_err);
            end
         end
         checks++;
         if (bus.busy !== (k != n - 1)) begin
            errors++;
            $display("FAIL busy_bit%0d: got %b, expected %b", k, bus.busy, (k != n - 1));
         end
         if (gaps && k != n - 1) begin
            bus.ser_valid = 1'b0;
            bus.ser_in    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_gap%0d: got %b, expected 1", k, bus.busy);
            end
         end
      end
      bus.ser_in = 1'b1;

      if (stop) begin
         if (!m_valid || ack_at_stop) begin
            sb_q.push_back({exp_perr, exp_word});
            m_valid = 1;
            m_word  = exp_word;
         end else begin
            m_ovr = 1;
         end
      end
      checks++;
      if (bus.frame_err !== !stop) begin
         errors++;
         $display("FAIL frame_err_stop: got %b, expected %b", bus.frame_err, !stop);
      end
      checks++;
      if ({bus.data_valid, bus.overrun, bus.data_out} !== {m_valid, m_ovr, m_word}) begin
         errors++;
         $display("FAIL after_stop: got valid=%b ovr=%b word=%b, expected valid=%b ovr=%b word=%b",
                  bus.data_valid, bus.overrun, bus.data_out, m_valid, m_ovr, m_word);
      end
   endtask

   task automatic do_ack();
      bus.data_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.data_ack = 1'b0;
      if (m_valid) begin
         m_valid = 0;
         m_ovr   = 0;
      end
      checks++;
      if ({bus.data_valid, bus.overrun, bus.parity_err} !== {m_valid, m_ovr, 1'b0}) begin
         errors++;
         $display("FAIL ack: got valid=%b ovr=%b perr=%b, expected valid=%b ovr=%b perr=0",
                  bus.data_valid, bus.overrun, bus.parity_err, m_valid, m_ovr);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      m_valid = 0;
      m_ovr   = 0;
      m_word  = '0;
      checks++;
      if ({bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy}
          !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got word=%b valid=%b perr=%b ferr=%b ovr=%b busy=%b, expected all 0",
                  bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, bus.busy);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL reset_pending: got %0d undelivered words, expected 0", sb_q.size());
         sb_q.delete();
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_msb_first();
      send_frame(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 0);
      do_ack();
   endtask

   task automatic test_lsb_first_gaps();
      send_frame(1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 1);
      do_ack();
   endtask

   task automatic test_parity();
      send_frame(1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 0);
      do_ack();
      send_frame(1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 0);
      do_ack();
      send_frame(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1);
      do_ack();
   endtask

   task automatic test_frame_err();
      send_frame(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 0);
      send_frame(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 0);
      do_ack();
   endtask

   task automatic test_overrun();
      send_frame(1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 0);
      send_frame(1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 0);
      do_ack();
      send_frame(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 0);
      send_frame(1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 0);
      do_ack();
   endtask

   task automatic test_back_to_back();
      send_frame(1'b0, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 0);
      send_frame(1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 0);
      do_ack();
   endtask

   task automatic test_reset_mid_frame();
      send_frame(1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 0);
      bus.dir       = 1'b1;
      bus.parity_en = 1'b0;
      bus.ser_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.ser_in = (k == 0) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
      end
      bus.ser_in = 1'b1;
      while (sb_q.size() != 0) void'(sb_q.pop_front());
      apply_reset();
      send_frame(1'b1, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0, 0);
      do_ack();
   endtask

   initial begin
      rst            = 1'b1;
      bus.ser_in     = 1'b1;
      bus.ser_valid  = 1'b0;
      bus.dir        = 1'b0;
      bus.parity_en  = 1'b0;
      bus.parity_odd = 1'b0;
      bus.data_ack   = 1'b0;

      test_reset();
      test_msb_first();
      test_lsb_first_gaps();
      test_parity();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL undelivered: got %0d words still pending, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
